main_mem_responder: RTL and testbench
=====================================

// Module: main_mem_responder
// PURPOSE
//  Memory-side responder for the cache/memory request interface. Services one
//  outstanding request at a time from a cache (I-cache refill, D-cache
//  refill/writeback): latches the request, waits a fixed LATENCY, then returns
//  one word with a single-cycle ready pulse. Acts as main-memory model and
//  protocol endpoint in cache lab top levels.
// PARAMETERS
//  ADDR_W   10  word-index width; memory holds 2**ADDR_W 32-bit words
//  LATENCY  4   cycles from accept to ready pulse; legal range 1..15
// PORTS
//  clk            in   1   clock; all state changes on rising edge
//  rst            in   1   synchronous, active-high reset
//  mem_req_valid  in   1   request valid; held high by requester until ready
//  mem_req_addr   in   32  byte address; word index = addr[ADDR_W+1:2]
//  mem_req_wr     in   1   1 = write, 0 = read
//  mem_wr_data    in   32  write data (used when mem_req_wr = 1)
//  mem_req_data   out  32  read data / write echo; valid while mem_req_ready = 1
//  mem_req_ready  out  1   one-cycle completion pulse
//  mem_busy       out  1   high while a request is accepted but not completed
// BEHAVIOUR
//  Reset: state IDLE, cnt 0, mem_req_ready 0, mem_req_data 0, mem_busy 0.
//   Memory array contents are not cleared by rst; zero at time 0.
//  FSM IDLE -> WAIT -> RESP -> IDLE. All outputs registered.
//  IDLE: if mem_req_valid=1, accept: latch addr index, wr, wr_data; cnt <=
//   LATENCY-1; next = RESP if LATENCY==1, else WAIT; mem_busy <= 1.
//  WAIT: cnt <= cnt-1; when cnt==1 go RESP. Inputs ignored (latched copy used).
//  RESP: mem_req_ready=1 for exactly this cycle; mem_busy=0 in this cycle.
//   Read: mem_req_data = mem[latched idx]. Write: mem[idx] <= latched data
//   on the edge ending RESP; mem_req_data echoes the written data.
//   Next state IDLE unconditionally.
//  Latency: accept in cycle T -> ready high in cycle T+LATENCY.
//  mem_req_data holds its last value when ready=0.
//  Back-to-back: earliest next accept is cycle T+LATENCY+1. Requester must drop
//   valid in that cycle unless issuing a new request; a still-high valid there
//   is accepted as a new request.
//  Valid deasserted during WAIT (protocol violation): transaction still
//   completes, ready still pulses, write still commits.
//  Address: bits [1:0] ignored; bits above ADDR_W+1 ignored (aliasing wrap).
//  Read-after-write to same word in next request returns new data.
//  rst mid-operation (WAIT or RESP): return to IDLE with reset output values;
//   pending write discarded; no ready pulse for the aborted request.
// TESTING
//  1 LATENCY=4: read addr 0x10 (word 4, preload 0xDEADBEEF), valid at T ->
//    ready only at T+4, data 0xDEADBEEF; busy high T+1..T+3.
//  2 Write 0x0000_0040 <- 0x12345678, then read 0x40 -> ready with
//    0x12345678; write ready cycle echoes 0x12345678.
//  3 ADDR_W=10: write 0x1000 <- 0xA5A5A5A5, read 0x0000 -> 0xA5A5A5A5
//    (wrap); read 0x0003 -> same word (low bits ignored).
//  4 Valid held high continuously for 3 reads: ready pulses at T+4, T+9, T+14;
//    never two consecutive ready cycles.
//  5 rst asserted at T+2 of a write to 0x20 (0x1 -> 0xFF): no ready, busy 0
//    next cycle, subsequent read 0x20 returns 0x1.
//  6 LATENCY=1: valid at T -> ready at T+1; valid dropped at T during WAIT
//    variant (LATENCY=4) -> ready still at T+4.

Source files
------------

// File: rtl/main_mem_responder.sv
// Main-memory model answering one cache request at a time with a single-word response.
// Latency: accept in cycle T, one-cycle ready pulse in cycle T+LATENCY (LATENCY 1..15).
// Backpressure: none; exactly one outstanding request, valid is sampled only while idle.
module main_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_valid,
    input  logic [31:0] mem_req_addr,
    input  logic        mem_req_wr,
    input  logic [31:0] mem_wr_data,
    output logic [31:0] mem_req_data,
    output logic        mem_req_ready,
    output logic        mem_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nx;
    logic              accept;
    logic              go_resp;

    // Latched copy of the accepted request; the live inputs are ignored after accept.
    logic [ADDR_W-1:0] idx_q;
    logic              wr_q;
    logic [31:0]       wd_q;

    // Request seen by the response path: the live inputs when responding straight
    // out of IDLE (LATENCY == 1), otherwise the latched copy.
    logic [ADDR_W-1:0] idx_in;
    logic [ADDR_W-1:0] resp_idx;
    logic              resp_wr;
    logic [31:0]       resp_wd;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    // Byte-offset bits and address bits above the array alias away.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{mem_req_addr[31:ADDR_W+2], mem_req_addr[1:0]};

    assign idx_in   = mem_req_addr[ADDR_W+1:2];
    assign resp_idx = accept ? idx_in        : idx_q;
    assign resp_wr  = accept ? mem_req_wr    : wr_q;
    assign resp_wd  = accept ? mem_wr_data   : wd_q;

    // Next-state logic: IDLE accepts, WAIT counts down, RESP always returns to IDLE.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        go_resp  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_valid) begin
                    accept = 1'b1;
                    cnt_nx = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_nx = RESP;
                        go_resp  = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = RESP;
                    go_resp  = 1'b1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, request latch and registered outputs; reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            idx_q         <= '0;
            wr_q          <= 1'b0;
            wd_q          <= 32'd0;
            mem_req_ready <= 1'b0;
            mem_req_data  <= 32'd0;
            mem_busy      <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            mem_req_ready <= go_resp;
            mem_busy      <= (state_nx == WAIT);
            if (accept) begin
                idx_q <= idx_in;
                wr_q  <= mem_req_wr;
                wd_q  <= mem_wr_data;
            end
            if (go_resp) begin
                mem_req_data <= resp_wr ? resp_wd : mem[resp_idx];
            end
        end
    end

    // Writes commit on the edge that ends RESP, so a reset during RESP discards them.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && wr_q) begin
            mem[idx_q] <= wd_q;
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: LATENCY=4 and LATENCY=1 instances, cycle model plus directed cases.
// The model tracks each instance's request by accept cycle and commits writes at accept+LATENCY.
// Inputs change #1 after posedge; outputs are compared on every negedge after the first reset.
module tb_main_mem_responder;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        valid [2];
    logic [31:0] addr  [2];
    logic        wr    [2];
    logic [31:0] wd    [2];
    logic [31:0] dat_o [2];
    logic        rdy_o [2];
    logic        bsy_o [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    main_mem_responder #(.ADDR_W(10), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst[0]), .mem_req_valid(valid[0]), .mem_req_addr(addr[0]),
        .mem_req_wr(wr[0]), .mem_wr_data(wd[0]), .mem_req_data(dat_o[0]),
        .mem_req_ready(rdy_o[0]), .mem_busy(bsy_o[0])
    );

    main_mem_responder #(.ADDR_W(10), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[1]), .mem_req_valid(valid[1]), .mem_req_addr(addr[1]),
        .mem_req_wr(wr[1]), .mem_wr_data(wd[1]), .mem_req_data(dat_o[1]),
        .mem_req_ready(rdy_o[1]), .mem_busy(bsy_o[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Reference model: a request accepted at cycle A answers at A+L and commits at the end of A+L.
    logic [31:0] mm    [2][1024];
    int          cyc = 0;
    logic        m_ok  [2] = '{1'b0, 1'b0};
    logic        pend  [2] = '{1'b0, 1'b0};
    int          acc   [2];
    logic [9:0]  p_idx [2];
    logic        p_wr  [2];
    logic [31:0] p_wd  [2];
    logic        e_rdy [2];
    logic        e_bsy [2];
    logic [31:0] e_dat [2];

    initial begin
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 1024; k++)
                mm[i][k] = 32'd0;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                pend[i]  = 1'b0;
                e_rdy[i] = 1'b0;
                e_bsy[i] = 1'b0;
                e_dat[i] = 32'd0;
                m_ok[i]  = 1'b1;
            end else if (pend[i] && cyc == acc[i] + lat_of(i)) begin
                if (p_wr[i]) mm[i][p_idx[i]] = p_wd[i];
                pend[i]  = 1'b0;
                e_rdy[i] = 1'b0;
                e_bsy[i] = 1'b0;
            end else if (pend[i]) begin
                e_rdy[i] = (cyc + 1 == acc[i] + lat_of(i));
                e_bsy[i] = !e_rdy[i];
                if (e_rdy[i]) e_dat[i] = p_wr[i] ? p_wd[i] : mm[i][p_idx[i]];
            end else if (valid[i]) begin
                pend[i]  = 1'b1;
                acc[i]   = cyc;
                p_idx[i] = addr[i][11:2];
                p_wr[i]  = wr[i];
                p_wd[i]  = wd[i];
                e_rdy[i] = (lat_of(i) == 1);
                e_bsy[i] = !e_rdy[i];
                if (e_rdy[i]) e_dat[i] = p_wr[i] ? p_wd[i] : mm[i][p_idx[i]];
            end else begin
                e_rdy[i] = 1'b0;
                e_bsy[i] = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_ok[i]) begin
                n_checks = n_checks + 3;
                if (rdy_o[i] !== e_rdy[i]) begin
                    n_errors = n_errors + 1;
                    $display("FAIL cmp_ready inst%0d cyc %0d got %0b want %0b", i, cyc, rdy_o[i], e_rdy[i]);
                end
                if (bsy_o[i] !== e_bsy[i]) begin
                    n_errors = n_errors + 1;
                    $display("FAIL cmp_busy inst%0d cyc %0d got %0b want %0b", i, cyc, bsy_o[i], e_bsy[i]);
                end
                if (dat_o[i] !== e_dat[i]) begin
                    n_errors = n_errors + 1;
                    $display("FAIL cmp_data inst%0d cyc %0d got %h want %h", i, cyc, dat_o[i], e_dat[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full request; entered and left 1 time unit after a posedge, valid dropped after ready.
    task automatic do_req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output int bcnt);
        valid[i] = 1'b1; addr[i] = a; wr[i] = w; wd[i] = d;
        lat = -1; bcnt = 0; rd = 32'd0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy_o[i] === 1'b1) begin
                lat = n;
                rd  = dat_o[i];
                break;
            end
            if (bsy_o[i] === 1'b1) bcnt++;
            step();
        end
        if (lat < 0) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL req_timeout inst%0d addr %h got no ready want ready", i, a);
            valid[i] = 1'b0;
        end else begin
            step();
            valid[i] = 1'b0;
        end
    endtask

    logic [31:0] rd;
    int          lat;
    int          bcnt;
    logic [31:0] r;
    int          k;
    int          n;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; valid[i] = 1'b0; addr[i] = 32'd0; wr[i] = 1'b0; wd[i] = 32'd0;
        end
        step(); step();
        for (int i = 0; i < 2; i++) rst[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_ready%0d", i), 32'(rdy_o[i]), 32'd0);
            chk($sformatf("reset_busy%0d", i), 32'(bsy_o[i]), 32'd0);
            chk($sformatf("reset_data%0d", i), dat_o[i], 32'd0);
        end
        step();

        // Preload words 0..15 on both instances; word 4 = DEADBEEF, word 8 = 1.
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 16; w++) begin
                r = (w == 4) ? 32'hDEADBEEF : (w == 8) ? 32'h1 : $urandom;
                do_req(i, 32'(w * 4), 1'b1, r, rd, lat, bcnt);
            end
        end

        // Read word 4: ready four cycles after accept, busy for the three cycles between.
        do_req(0, 32'h10, 1'b0, 32'h0, rd, lat, bcnt);
        chk("t1_latency", 32'(lat), 32'd4);
        chk("t1_data", rd, 32'hDEADBEEF);
        chk("t1_busy_cycles", 32'(bcnt), 32'd3);

        // Write echo, then read-after-write.
        do_req(0, 32'h40, 1'b1, 32'h12345678, rd, lat, bcnt);
        chk("t2_write_echo", rd, 32'h12345678);
        do_req(0, 32'h40, 1'b0, 32'h0, rd, lat, bcnt);
        chk("t2_read_back", rd, 32'h12345678);

        // Upper address bits and byte offset alias to the same word.
        do_req(0, 32'h1000, 1'b1, 32'hA5A5A5A5, rd, lat, bcnt);
        do_req(0, 32'h0000, 1'b0, 32'h0, rd, lat, bcnt);
        chk("t3_wrap", rd, 32'hA5A5A5A5);
        do_req(0, 32'h0003, 1'b0, 32'h0, rd, lat, bcnt);
        chk("t3_low_bits", rd, 32'hA5A5A5A5);

        // Valid held for three reads: pulses at offsets 4, 9, 14 only.
        valid[0] = 1'b1; addr[0] = 32'h10; wr[0] = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk($sformatf("t4_ready_at_%0d", c), 32'(rdy_o[0]), 32'((c == 4) || (c == 9) || (c == 14)));
            step();
        end
        valid[0] = 1'b0;
        step();

        // Reset two cycles into a write: no pulse, write lost.
        valid[0] = 1'b1; addr[0] = 32'h20; wr[0] = 1'b1; wd[0] = 32'hFF;
        step(); step();
        rst[0] = 1'b1; valid[0] = 1'b0;
        step();
        rst[0] = 1'b0;
        @(negedge clk);
        chk("t5_no_ready", 32'(rdy_o[0]), 32'd0);
        chk("t5_busy_clear", 32'(bsy_o[0]), 32'd0);
        step();
        do_req(0, 32'h20, 1'b0, 32'h0, rd, lat, bcnt);
        chk("t5_write_discarded", rd, 32'h1);

        // LATENCY=1 instance, then valid dropped after accept on the LATENCY=4 instance.
        do_req(1, 32'h10, 1'b0, 32'h0, rd, lat, bcnt);
        chk("t6_lat1_latency", 32'(lat), 32'd1);
        chk("t6_lat1_data", rd, 32'hDEADBEEF);
        valid[0] = 1'b1; addr[0] = 32'h10; wr[0] = 1'b0;
        step();
        valid[0] = 1'b0;
        lat = -1;
        for (n = 1; n < 20; n++) begin
            @(negedge clk);
            if (rdy_o[0] === 1'b1) begin
                lat = n;
                break;
            end
            step();
        end
        chk("t6_drop_latency", 32'(lat), 32'd4);
        step();

        // Random traffic on both instances, including protocol violations and resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                r        = $urandom;
                k        = $urandom_range(0, 15);
                rst[i]   = ($urandom_range(0, 99) == 0);
                valid[i] = ($urandom_range(0, 9) < 6);
                addr[i]  = {r[31:12], 6'b0, 4'(k), r[1:0]};
                wr[i]    = r[2];
                wd[i]    = $urandom;
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; valid[i] = 1'b0;
        end
        step(); step(); step(); step(); step(); step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
